mpu_spi_master: RTL

SPI master byte transactor for the MPU9250 sensor link. It sits directly below the gyro/accel register-read controller. It accepts one register access per `start` pulse and runs a single 16-bit mode-3 SPI frame (R/W bit, 7-bit address, 8-bit data). It returns the read byte and a `busy` flag that the controller polls between accesses.

---
 rtl/mpu_spi_master.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mpu_spi_master.sv
// SPI mode-3 master for the MPU9250 link: one 16-bit frame {rw, addr[6:0], data[7:0]}
// per accepted start, MSB first, with a guaranteed SS-high gap before busy drops.
module mpu_spi_master #(
  parameter int unsigned CLK_DIV = 50,
  parameter int unsigned CS_GAP  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] mpu_address,
  input  logic [7:0] mpu_wr_data,
  input  logic       mpu_rd_wr_sel,
  input  logic       start,
  output logic       busy,
  output logic [7:0] mpu_rd_data,
  output logic       SPI_SS_g,
  output logic       SPI_CK_g,
  output logic       SPI_DO_g,
  input  logic       SPI_DI_g
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] tx;
  logic [15:0] rx;
  logic        rd_sel;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      tx          <= '0;
      rx          <= '0;
      rd_sel      <= 1'b0;
      busy        <= 1'b0;
      mpu_rd_data <= '0;
      SPI_SS_g    <= 1'b1;
      SPI_CK_g    <= 1'b1;
      SPI_DO_g    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tx       <= {mpu_rd_wr_sel, mpu_address, mpu_rd_wr_sel ? 8'h00 : mpu_wr_data};
            rd_sel   <= mpu_rd_wr_sel;
            busy     <= 1'b1;
            SPI_SS_g <= 1'b0;
            cnt      <= '0;
            bit_cnt  <= '0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            SPI_CK_g <= 1'b0;
            SPI_DO_g <= tx[15];
            state    <= LOW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        LOW: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            SPI_CK_g <= 1'b1;
            rx       <= {rx[14:0], SPI_DI_g};  // MISO sampled on the SCLK rising edge
            state    <= HIGH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        HIGH: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            tx      <= {tx[14:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state <= HOLD;
            end else begin
              SPI_CK_g <= 1'b0;
              SPI_DO_g <= tx[14];  // next bit, i.e. tx[15] after this edge's shift
              state    <= LOW;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            SPI_SS_g <= 1'b1;
            state    <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            busy     <= 1'b0;
            SPI_DO_g <= 1'b0;
            if (rd_sel) mpu_rd_data <= rx[7:0];
            state    <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
